// File: rtl/bus_sync_qual.sv
// bus_sync_qual: multi-stage bus synchronizer whose output only follows values
// that have stayed stable for STABLE_CYC destination cycles.
module bus_sync_qual #(
    parameter int                Bus_BW     = 4,
    parameter int                SYNC_STG   = 2,
    parameter int                STABLE_CYC = 3,
    parameter logic [Bus_BW-1:0] RST_VAL    = '0
) (
    input  logic              dest_clk,
    input  logic              dest_rstn,
    input  logic [Bus_BW-1:0] Bus_in,
    output logic [Bus_BW-1:0] Bus_sync,
    output logic              upd_pulse,
    output logic              busy,
    output logic [7:0]        rej_cnt
);
    localparam int CW = STABLE_CYC > 1 ? $clog2(STABLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

    if (SYNC_STG < 2 || SYNC_STG > 4) begin : g_bad_stg
        $fatal(1, "bus_sync_qual: SYNC_STG must be 2..4");
    end

    logic [Bus_BW-1:0] sync_r [SYNC_STG];
    logic [Bus_BW-1:0] sync_q;
    logic [Bus_BW-1:0] cand;
    logic [CW-1:0]     cnt;

    assign sync_q = sync_r[SYNC_STG-1];
    assign busy   = (sync_q != cand) || (cand != Bus_sync);

    always_ff @(posedge dest_clk or negedge dest_rstn) begin
        if (!dest_rstn) begin
            for (int i = 0; i < SYNC_STG; i++) sync_r[i] <= RST_VAL;
        end else begin
            sync_r[0] <= Bus_in;
            for (int i = 1; i < SYNC_STG; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    // A new sample restarts qualification; a still-pending candidate counts as rejected.
    always_ff @(posedge dest_clk or negedge dest_rstn) begin
        if (!dest_rstn) begin
            cand      <= RST_VAL;
            Bus_sync  <= RST_VAL;
            cnt       <= '0;
            upd_pulse <= 1'b0;
            rej_cnt   <= '0;
        end else begin
            upd_pulse <= 1'b0;
            if (sync_q != cand) begin
                cand <= sync_q;
                cnt  <= '0;
                if (cand != Bus_sync && rej_cnt != 8'hff) rej_cnt <= rej_cnt + 8'd1;
            end else if (cand != Bus_sync) begin
                if (cnt == CNT_MAX) begin
                    Bus_sync  <= cand;
                    upd_pulse <= 1'b1;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_bus_sync_qual.sv
// tb_bus_sync_qual: directed + randomized check of two bus_sync_qual configurations
// against a run-length reference model of the qualified bus.
module tb_bus_sync_qual;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] bin0, bs0;
    logic [7:0] bin1, bs1, rej0, rej1;
    logic       up0, up1, busy0, busy1;

    always #13 clk = ~clk;

    bus_sync_qual dut0 (
        .dest_clk(clk), .dest_rstn(rstn), .Bus_in(bin0), .Bus_sync(bs0),
        .upd_pulse(up0), .busy(busy0), .rej_cnt(rej0)
    );

    bus_sync_qual #(.Bus_BW(8), .SYNC_STG(3), .STABLE_CYC(1), .RST_VAL(8'h00)) dut1 (
        .dest_clk(clk), .dest_rstn(rstn), .Bus_in(bin1), .Bus_sync(bs1),
        .upd_pulse(up1), .busy(busy1), .rej_cnt(rej1)
    );

    int errs = 0, checks = 0;
    int np0, np1, lat0, lat1, sb0;
    logic [3:0] base0;
    logic [7:0] base1;

    // Reference model: sampled value history, run length of identical samples.
    int         stg [2] = '{2, 3};
    int         stb [2] = '{3, 1};
    logic [7:0] hist [2][16];
    logic [7:0] m_cand [2];
    logic [7:0] m_out [2];
    logic       m_upd [2];
    int         rl [2];
    int         m_rej [2];
    int         ek;

    function automatic logic [7:0] sample(int d, int e);
        return e >= stg[d] ? hist[d][(e - stg[d]) % 16] : 8'h00;
    endfunction

    function automatic logic m_busy(int d);
        return (sample(d, ek) != m_cand[d]) || (m_cand[d] != m_out[d]);
    endfunction

    task automatic model_reset();
        ek = 0;
        for (int d = 0; d < 2; d++) begin
            m_cand[d] = 8'h00;
            m_out[d]  = 8'h00;
            m_upd[d]  = 1'b0;
            rl[d]     = 1;
            m_rej[d]  = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            logic [7:0] s;
            s = sample(d, ek);
            m_upd[d] = 1'b0;
            if (s != m_cand[d]) begin
                if (m_cand[d] != m_out[d] && m_rej[d] < 255) m_rej[d]++;
                rl[d] = 1;
            end else begin
                rl[d]++;
            end
            if (s != m_out[d] && rl[d] >= stb[d] + 1) begin
                m_out[d] = s;
                m_upd[d] = 1'b1;
            end
            m_cand[d] = s;
            hist[d][ek % 16] = d == 0 ? {4'h0, bin0} : bin1;
        end
        ek++;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("bs0",   32'(bs0),   32'(m_out[0][3:0]));
        chk("upd0",  32'(up0),   32'(m_upd[0]));
        chk("busy0", 32'(busy0), 32'(m_busy(0)));
        chk("rej0",  32'(rej0),  32'(m_rej[0]));
        chk("bs1",   32'(bs1),   32'(m_out[1]));
        chk("upd1",  32'(up1),   32'(m_upd[1]));
        chk("busy1", 32'(busy1), 32'(m_busy(1)));
        chk("rej1",  32'(rej1),  32'(m_rej[1]));
    endtask

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rstn) model_edge();
            @(negedge clk);
            check_all();
            if (up0) np0++;
            if (up1) np1++;
            if (busy0) sb0 = 1;
        end
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_bs0"},   32'(bs0),   32'h0);
        chk({tag, "_upd0"},  32'(up0),   32'h0);
        chk({tag, "_rej0"},  32'(rej0),  32'h0);
        chk({tag, "_busy0"}, 32'(busy0), 32'h0);
        chk({tag, "_bs1"},   32'(bs1),   32'h0);
        chk({tag, "_upd1"},  32'(up1),   32'h0);
        chk({tag, "_rej1"},  32'(rej1),  32'h0);
        chk({tag, "_busy1"}, 32'(busy1), 32'h0);
    endtask

    initial begin
        bin0 = 4'b0111;
        bin1 = 8'hA5;
        np0 = 0; np1 = 0; sb0 = 0;
        model_reset();
        step(3);
        check_reset_outputs("reset");
        rstn = 1'b1;
        np0 = 0; np1 = 0;
        step(10);
        chk("rel_bs0", 32'(bs0), 32'h7);
        chk("rel_pulses0", 32'(np0), 32'd1);
        chk("rel_bs1", 32'(bs1), 32'hA5);
        chk("rel_pulses1", 32'(np1), 32'd1);

        // Clean step latency from the first capturing edge
        bin0 = 4'b1000;
        bin1 = 8'h3C;
        lat0 = -1; lat1 = -1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (up0 && lat0 < 0) lat0 = i;
            if (up1 && lat1 < 0) lat1 = i;
        end
        chk("lat0", 32'(lat0), 32'd5);
        chk("lat1", 32'(lat1), 32'd4);
        chk("lat_bs0", 32'(bs0), 32'h8);
        chk("lat_bs1", 32'(bs1), 32'h3C);

        // Clean toggles with random hold lengths
        np0 = 0; np1 = 0;
        for (int i = 0; i < 5; i++) begin
            bin0 = bin0 == 4'b0111 ? 4'b1000 : 4'b0111;
            bin1 = bin1 ^ 8'($urandom_range(1, 255));
            step($urandom_range(8, 20));
        end
        chk("toggle_pulses0", 32'(np0), 32'd5);
        chk("toggle_pulses1", 32'(np1), 32'd5);
        chk("toggle_rej0", 32'(rej0), 32'd0);
        chk("toggle_bs0", 32'(bs0), 32'h7);

        // One-cycle glitch
        np0 = 0; sb0 = 0;
        bin0 = 4'b1000;
        step(1);
        bin0 = 4'b0111;
        step(8);
        chk("glitch_bs0", 32'(bs0), 32'h7);
        chk("glitch_pulses0", 32'(np0), 32'd0);
        chk("glitch_rej0", 32'(rej0), 32'd1);
        chk("glitch_busy_seen", 32'(sb0), 32'd1);
        chk("glitch_busy_end", 32'(busy0), 32'd0);

        // Skewed multi-bit transition
        np0 = 0;
        bin0 = 4'b0110; step(1);
        bin0 = 4'b0000; step(1);
        bin0 = 4'b1000; step(10);
        chk("skew_bs0", 32'(bs0), 32'h8);
        chk("skew_pulses0", 32'(np0), 32'd1);
        chk("skew_rej0", 32'(rej0), 32'd3);

        // Random traffic with short holds
        for (int i = 0; i < 80; i++) begin
            bin0 = 4'($urandom);
            bin1 = 8'($urandom);
            step($urandom_range(1, 6));
        end

        // Saturation of the rejection counter
        step(10);
        base0 = bin0;
        base1 = bin1;
        for (int i = 0; i < 300; i++) begin
            bin0 = ~base0; bin1 = ~base1; step(1);
            bin0 = base0;  bin1 = base1;  step(1);
        end
        step(6);
        chk("sat_rej0", 32'(rej0), 32'd255);
        chk("sat_rej1", 32'(rej1), 32'd255);
        chk("sat_bs0", 32'(bs0), 32'(base0));
        chk("sat_bs1", 32'(bs1), 32'(base1));
        for (int i = 0; i < 5; i++) begin
            bin0 = ~base0; step(1);
            bin0 = base0;  step(1);
        end
        chk("sat_hold_rej0", 32'(rej0), 32'd255);

        // Reset while a candidate is qualifying
        bin0 = base0 == 4'h5 ? 4'hA : 4'h5;
        bin1 = base1 == 8'h5A ? 8'hA5 : 8'h5A;
        step(4);
        chk("mid_busy0", 32'(busy0), 32'd1);
        chk("mid_busy1", 32'(busy1), 32'd1);
        #3 rstn = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_rst");
        np0 = 0; np1 = 0;
        step(2);
        chk("rst_pulses0", 32'(np0), 32'd0);
        rstn = 1'b1;
        step(12);
        chk("reacq_bs0", 32'(bs0), 32'(bin0));
        chk("reacq_pulses0", 32'(np0), 32'd1);
        chk("reacq_bs1", 32'(bs1), 32'(bin1));
        chk("reacq_pulses1", 32'(np1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
